// File: rtl/add_seq8.sv
// add_seq8: multi-byte adder that reuses one external 8-bit adder, one byte per cycle.
// Optional subtract mode is compiled in when ADDSEQ_SUB_EN is defined.
module add_seq8 #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  output logic                  RDY,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  CI,
`ifdef ADDSEQ_SUB_EN
  input  logic                  SUB,
`endif
  output logic [8*NBYTES-1:0]   S,
  output logic                  CO,
  output logic                  VLD,
  input  logic                  ACK,
  output logic [7:0]            AA,
  output logic [7:0]            AB,
  output logic                  ACI,
  input  logic [7:0]            AS,
  input  logic                  ACO
);

  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              st;
  state_t              nxt;
  logic [KW-1:0]       k;
  logic [8*NBYTES-1:0] a_q;
  logic [8*NBYTES-1:0] b_q;
  logic [8*NBYTES-1:0] s_q;
  logic                ci_q;
  logic                co_q;
  logic                carry_q;
  logic [7:0]          a_byte;
  logic [7:0]          b_byte;
  logic                cin0;
  logic                last;

`ifdef ADDSEQ_SUB_EN
  logic sub_q;
`endif

  assign last   = (k == KLAST);
  assign a_byte = a_q[8*k +: 8];

`ifdef ADDSEQ_SUB_EN
  // Subtract as A + ~B + 1; the initial carry replaces CI.
  assign b_byte = sub_q ? ~b_q[8*k +: 8] : b_q[8*k +: 8];
  assign cin0   = sub_q | ci_q;
`else
  assign b_byte = b_q[8*k +: 8];
  assign cin0   = ci_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (REQ)  nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (ACK)  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (st == IDLE) begin
      if (REQ) begin
        a_q     <= A;
        b_q     <= B;
        ci_q    <= CI;
        k       <= '0;
        carry_q <= 1'b0;
`ifdef ADDSEQ_SUB_EN
        sub_q   <= SUB;
`endif
      end
    end else if (st == RUN) begin
      s_q[8*k +: 8] <= AS;
      carry_q       <= ACO;
      if (last) co_q <= ACO;
      else      k    <= k + KW'(1);
    end
  end

  always_comb begin
    AA  = 8'h00;
    AB  = 8'h00;
    ACI = 1'b0;
    if (st == RUN) begin
      AA  = a_byte;
      AB  = b_byte;
      ACI = (k == '0) ? cin0 : carry_q;
    end
  end

  assign RDY = (st == IDLE) && !RST;
  assign VLD = (st == DONE);
  assign S   = s_q;
  assign CO  = co_q;

endmodule

// File: tb/tb_add_seq8.sv
// tb_add_seq8: directed scoreboard bench for add_seq8 (NBYTES=4).
// Drives and samples 1 time unit after each rising edge; models the byte adder.
module tb_add_seq8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ;
  logic        RDY;
  logic [31:0] A;
  logic [31:0] B;
  logic        CI;
`ifdef ADDSEQ_SUB_EN
  logic        SUB;
`endif
  logic [31:0] S;
  logic        CO;
  logic        VLD;
  logic        ACK;
  logic [7:0]  AA;
  logic [7:0]  AB;
  logic        ACI;
  logic [7:0]  AS;
  logic        ACO;

  int total = 0;
  int bad   = 0;

  logic [32:0] sb[$];
  logic [7:0]  aa_log[4];
  logic        aci_log[4];

  always #5 CLK = ~CLK;

  assign {ACO, AS} = {1'b0, AA} + {1'b0, AB} + {8'b0, ACI};

  add_seq8 #(.NBYTES(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
    .RDY(RDY),
    .A(A),
    .B(B),
    .CI(CI),
`ifdef ADDSEQ_SUB_EN
    .SUB(SUB),
`endif
    .S(S),
    .CO(CO),
    .VLD(VLD),
    .ACK(ACK),
    .AA(AA),
    .AB(AB),
    .ACI(ACI),
    .AS(AS),
    .ACO(ACO)
  );

  function automatic logic [32:0] model(
    input logic [31:0] a, input logic [31:0] b,
    input logic ci, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sub);
    int n = 0;
    A   = a;
    B   = b;
    CI  = ci;
`ifdef ADDSEQ_SUB_EN
    SUB = sub;
`endif
    REQ = 1'b1;
    while (!RDY && n < 20) begin
      tick;
      n++;
    end
    chk("rdy_wait", {63'd0, RDY}, 64'd1);
    sb.push_back(model(a, b, ci, sub));
    tick;
    REQ = 1'b0;
    A   = $urandom;
    B   = $urandom;
  endtask

  task automatic wait_res;
    int n = 0;
    logic [32:0] e;
    while (!VLD && n < 20) begin
      if (n < 4) begin
        aa_log[n]  = AA;
        aci_log[n] = ACI;
      end
      tick;
      n++;
    end
    chk("latency", 64'(n), 64'd4);
    chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", {32'd0, S}, {32'd0, e[31:0]});
      chk("carry", {63'd0, CO}, {63'd0, e[32]});
    end
  endtask

  task automatic do_ack;
    ACK = 1'b1;
    tick;
    ACK = 1'b0;
    chk("ack_vld", {63'd0, VLD}, 64'd0);
    chk("ack_rdy", {63'd0, RDY}, 64'd1);
  endtask

  initial begin
    logic [31:0] ref_a;
    logic [31:0] s0;
    logic [32:0] e;
    int accepts;
    int results;
    int n;
    bit took;

    RST = 1'b1;
    REQ = 1'b1;
    ACK = 1'b0;
    A   = 32'hDEADBEEF;
    B   = 32'h1;
    CI  = 1'b1;
`ifdef ADDSEQ_SUB_EN
    SUB = 1'b0;
`endif
    tick;
    tick;
    chk("rst_rdy", {63'd0, RDY}, 64'd0);
    chk("rst_vld", {63'd0, VLD}, 64'd0);
    chk("rst_s", {32'd0, S}, 64'd0);
    chk("rst_co", {63'd0, CO}, 64'd0);
    chk("rst_aa", {56'd0, AA}, 64'd0);
    chk("rst_ab", {56'd0, AB}, 64'd0);
    chk("rst_aci", {63'd0, ACI}, 64'd0);
    REQ = 1'b0;
    RST = 1'b0;
    #1;
    chk("rst_rdy_rel", {63'd0, RDY}, 64'd1);

    // full carry ripple through all bytes
    start_op(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    wait_res;
    for (int i = 0; i < 4; i++)
      chk("ripple_aci", {63'd0, aci_log[i]}, 64'd1);
    do_ack;

    // byte order on the adder port
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_res;
    ref_a = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      chk("aa_byte", {56'd0, aa_log[i]}, {56'd0, ref_a[7:0]});
      chk("aci_zero", {63'd0, aci_log[i]}, 64'd0);
      ref_a = ref_a >> 8;
    end
    do_ack;

    start_op(32'h00FF00FF, 32'h00010001, 1'b0, 1'b0);
    wait_res;
    do_ack;
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    wait_res;
    do_ack;

    // result held while consumer stalls
    start_op(32'hCAFE0001, 32'h0000FFFF, 1'b0, 1'b0);
    wait_res;
    s0  = S;
    REQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      A = $urandom;
      tick;
      chk("hold_s", {32'd0, S}, {32'd0, s0});
      chk("hold_vld", {63'd0, VLD}, 64'd1);
      chk("hold_rdy", {63'd0, RDY}, 64'd0);
    end
    do_ack;
    REQ = 1'b0;

    // reset aborts an operation mid-run
    start_op(32'hA1B2C3D4, 32'h01010101, 1'b1, 1'b0);
    tick;
    tick;
    chk("aa_k2", {56'd0, AA}, 64'hB2);
    RST = 1'b1;
    tick;
    chk("abort_vld", {63'd0, VLD}, 64'd0);
    chk("abort_s", {32'd0, S}, 64'd0);
    chk("abort_co", {63'd0, CO}, 64'd0);
    chk("abort_aa", {56'd0, AA}, 64'd0);
    chk("abort_rdy", {63'd0, RDY}, 64'd0);
    sb.delete();
    RST = 1'b0;
    #1;
    chk("abort_rdy_rel", {63'd0, RDY}, 64'd1);
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_res;
    do_ack;

`ifdef ADDSEQ_SUB_EN
    start_op(32'd5, 32'd7, 1'b0, 1'b1);
    wait_res;
    do_ack;
    start_op(32'd7, 32'd5, 1'b0, 1'b1);
    wait_res;
    do_ack;
    start_op(32'd7, 32'd5, 1'b1, 1'b0);
    wait_res;
    do_ack;
`endif

    // back-to-back with REQ and ACK held high
    accepts = 0;
    results = 0;
    REQ = 1'b1;
    ACK = 1'b1;
    A   = $urandom;
    B   = $urandom;
    CI  = 1'($urandom);
    for (int c = 0; c < 60; c++) begin
      took = 1'b0;
      if (RDY && REQ) begin
        sb.push_back(model(A, B, CI, 1'b0));
        accepts++;
        took = 1'b1;
      end
      if (VLD && ACK) begin
        chk("b2b_nonempty", {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_sum", {32'd0, S}, {32'd0, e[31:0]});
          chk("b2b_carry", {63'd0, CO}, {63'd0, e[32]});
        end
        results++;
      end
      tick;
      if (took) begin
        A  = $urandom;
        B  = $urandom;
        CI = 1'($urandom);
      end
    end
    REQ = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      if (VLD) begin
        e = sb.pop_front();
        chk("drain_sum", {32'd0, S}, {32'd0, e[31:0]});
        chk("drain_carry", {63'd0, CO}, {63'd0, e[32]});
        results++;
      end
      tick;
      n++;
    end
    ACK = 1'b0;
    chk("b2b_count", 64'(results), 64'(accepts));
    chk("b2b_accepts", 64'(accepts), 64'd10);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
